// File: rtl/hazard_pkg.sv
//------------------------------------------------------------------------------
// Module   : hazard_pkg
// Brief    : Shared types and constants for the miniRV hazard sequencer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package hazard_pkg;

    typedef logic [1:0] state_t;

    localparam state_t RUN      = 2'd0;
    localparam state_t LU_STALL = 2'd1;
    localparam state_t FLUSH    = 2'd2;
    localparam state_t MEM_WAIT = 2'd3;

    localparam logic [4:0] REG_X0 = 5'd0;
    localparam int         CNT_W  = 3;

endpackage

`default_nettype wire

// File: rtl/hazard_detect.sv
//------------------------------------------------------------------------------
// Module   : hazard_detect
// Brief    : Combinational load-use comparator between ID sources and EX rd.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module hazard_detect
    import hazard_pkg::*;
(
    input  logic [4:0] i_id_rs1,
    input  logic [4:0] i_id_rs2,
    input  logic       i_id_rs1_used,
    input  logic       i_id_rs2_used,
    input  logic [4:0] i_ex_rd,
    input  logic       i_ex_wen,
    input  logic       i_ex_is_load,
    output logic       o_lu_hit
);

    logic w_rs1_match;
    logic w_rs2_match;

    assign w_rs1_match = i_id_rs1_used && (i_id_rs1 == i_ex_rd);
    assign w_rs2_match = i_id_rs2_used && (i_id_rs2 == i_ex_rd);

    // x0 is hardwired zero, so a load targeting it never creates a dependency
    assign o_lu_hit = i_ex_is_load && i_ex_wen && (i_ex_rd != REG_X0) &&
                      (w_rs1_match || w_rs2_match);

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
//------------------------------------------------------------------------------
// Module   : hazard_ctrl
// Brief    : Stall/flush sequencer for the 5-stage pipeline (load-use, redirect,
//            memory wait). Define HAZARD_PERF_CNT_EN for saturating perf counters.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int LOAD_USE_CYCLES = 1,
    parameter int FLUSH_CYCLES    = 1
)(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [4:0] id_rs1_i,
    input  logic [4:0] id_rs2_i,
    input  logic       id_rs1_used_i,
    input  logic       id_rs2_used_i,
    input  logic [4:0] ex_rd_i,
    input  logic       ex_wen_i,
    input  logic       ex_is_load_i,
    input  logic       ex_redirect_i,
    input  logic       mem_busy_i,
    output logic       keep_pc_o,
    output logic       keep_if_id_o,
    output logic       keep_id_ex_o,
    output logic       flush_if_id_o,
    output logic       bubble_id_ex_o,
    output logic [1:0] state_o
`ifdef HAZARD_PERF_CNT_EN
   ,output logic [31:0] lu_stall_cnt_o,
    output logic [31:0] flush_cnt_o,
    output logic [31:0] mem_wait_cnt_o
`endif
);

    if (LOAD_USE_CYCLES < 1 || LOAD_USE_CYCLES > 7) begin : g_lu_range_err
        $error("LOAD_USE_CYCLES must be in 1..7");
    end
    if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 7) begin : g_fl_range_err
        $error("FLUSH_CYCLES must be in 1..7");
    end

    localparam logic [CNT_W-1:0] c_lu_reload = CNT_W'(LOAD_USE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_fl_reload = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);
    localparam state_t           c_lu_next   = (LOAD_USE_CYCLES > 1) ? LU_STALL : RUN;
    localparam state_t           c_fl_next   = (FLUSH_CYCLES > 1) ? FLUSH : RUN;

    state_t           r_state, r_ret_state;
    state_t           w_eff_state, w_next_state, w_next_ret;
    logic [CNT_W-1:0] r_cnt, w_next_cnt;
    logic             w_lu_hit;
    logic             w_lu_bubble;

    hazard_detect u_detect (
        .i_id_rs1      (id_rs1_i),
        .i_id_rs2      (id_rs2_i),
        .i_id_rs1_used (id_rs1_used_i),
        .i_id_rs2_used (id_rs2_used_i),
        .i_ex_rd       (ex_rd_i),
        .i_ex_wen      (ex_wen_i),
        .i_ex_is_load  (ex_is_load_i),
        .o_lu_hit      (w_lu_hit)
    );

    always_comb begin
        // Leaving MEM_WAIT resumes the preempted state within the same cycle
        w_eff_state    = (r_state == MEM_WAIT && !mem_busy_i) ? r_ret_state : r_state;
        keep_pc_o      = 1'b0;
        keep_if_id_o   = 1'b0;
        keep_id_ex_o   = 1'b0;
        flush_if_id_o  = 1'b0;
        bubble_id_ex_o = 1'b0;
        w_lu_bubble    = 1'b0;
        w_next_state   = RUN;
        w_next_cnt     = r_cnt;
        w_next_ret     = r_ret_state;

        if (mem_busy_i) begin
            keep_pc_o    = 1'b1;
            keep_if_id_o = 1'b1;
            keep_id_ex_o = 1'b1;
            w_next_state = MEM_WAIT;
            if (r_state != MEM_WAIT) begin
                w_next_ret = r_state;
            end
        end else if (ex_redirect_i) begin
            flush_if_id_o  = 1'b1;
            bubble_id_ex_o = 1'b1;
            w_next_cnt     = c_fl_reload;
            w_next_state   = c_fl_next;
        end else begin
            case (w_eff_state)
                LU_STALL: begin
                    keep_pc_o      = 1'b1;
                    keep_if_id_o   = 1'b1;
                    bubble_id_ex_o = 1'b1;
                    w_lu_bubble    = 1'b1;
                    w_next_cnt     = r_cnt - c_cnt_one;
                    w_next_state   = (r_cnt == c_cnt_one) ? RUN : LU_STALL;
                end
                FLUSH: begin
                    flush_if_id_o = 1'b1;
                    w_next_cnt    = r_cnt - c_cnt_one;
                    w_next_state  = (r_cnt == c_cnt_one) ? RUN : FLUSH;
                end
                default: begin
                    if (w_lu_hit) begin
                        keep_pc_o      = 1'b1;
                        keep_if_id_o   = 1'b1;
                        bubble_id_ex_o = 1'b1;
                        w_lu_bubble    = 1'b1;
                        w_next_cnt     = c_lu_reload;
                        w_next_state   = c_lu_next;
                    end
                end
            endcase
        end

        if (rst_i) begin
            keep_pc_o      = 1'b0;
            keep_if_id_o   = 1'b0;
            keep_id_ex_o   = 1'b0;
            flush_if_id_o  = 1'b1;
            bubble_id_ex_o = 1'b1;
            w_lu_bubble    = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= RUN;
            r_ret_state <= RUN;
            r_cnt       <= '0;
        end else begin
            r_state     <= w_next_state;
            r_ret_state <= w_next_ret;
            r_cnt       <= w_next_cnt;
        end
    end

    assign state_o = r_state;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] r_lu_stall_cnt, r_flush_cnt, r_mem_wait_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_lu_stall_cnt <= '0;
            r_flush_cnt    <= '0;
            r_mem_wait_cnt <= '0;
        end else begin
            if (w_lu_bubble && r_lu_stall_cnt != '1) begin
                r_lu_stall_cnt <= r_lu_stall_cnt + 32'd1;
            end
            if (flush_if_id_o && r_flush_cnt != '1) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
            if (r_state == MEM_WAIT && r_mem_wait_cnt != '1) begin
                r_mem_wait_cnt <= r_mem_wait_cnt + 32'd1;
            end
        end
    end

    assign lu_stall_cnt_o = r_lu_stall_cnt;
    assign flush_cnt_o    = r_flush_cnt;
    assign mem_wait_cnt_o = r_mem_wait_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_hazard_ctrl
// Brief    : Scoreboard bench for hazard_ctrl; two instances (L=1/F=1, L=3/F=2)
//            share stimulus and are checked every cycle.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_hazard_ctrl;

    // Expected word: {state[1:0], keep_pc, keep_if_id, keep_id_ex, flush, bubble}
    localparam logic [6:0] E_IDLE   = 7'b00_00000;
    localparam logic [6:0] E_RST    = 7'b00_00011;
    localparam logic [6:0] E_LU     = 7'b00_11001;
    localparam logic [6:0] E_LUS    = 7'b01_11001;
    localparam logic [6:0] E_RED    = 7'b00_00011;
    localparam logic [6:0] E_FL     = 7'b10_00010;
    localparam logic [6:0] E_FLR    = 7'b10_00011;
    localparam logic [6:0] E_MB0    = 7'b00_11100;
    localparam logic [6:0] E_MB1    = 7'b01_11100;
    localparam logic [6:0] E_MW     = 7'b11_11100;
    localparam logic [6:0] E_MW_RUN = 7'b11_00000;
    localparam logic [6:0] E_MW_LU  = 7'b11_11001;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic       id_rs1_used = 1'b0, id_rs2_used = 1'b0;
    logic       ex_wen = 1'b0, ex_is_load = 1'b0, ex_redirect = 1'b0, mem_busy = 1'b0;

    logic       kp_a, ki_a, ke_a, fl_a, bb_a;
    logic       kp_b, ki_b, ke_b, fl_b, bb_b;
    logic [1:0] st_a, st_b;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] lu_a, fc_a, mw_a, lu_b, fc_b, mw_b;
`endif

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [6:0] ea;
        logic [6:0] eb;
        string      name;
    } exp_t;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    hazard_ctrl #(.LOAD_USE_CYCLES(1), .FLUSH_CYCLES(1)) dut_a (
        .clk_i(clk), .rst_i(rst),
        .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
        .id_rs1_used_i(id_rs1_used), .id_rs2_used_i(id_rs2_used),
        .ex_rd_i(ex_rd), .ex_wen_i(ex_wen), .ex_is_load_i(ex_is_load),
        .ex_redirect_i(ex_redirect), .mem_busy_i(mem_busy),
        .keep_pc_o(kp_a), .keep_if_id_o(ki_a), .keep_id_ex_o(ke_a),
        .flush_if_id_o(fl_a), .bubble_id_ex_o(bb_a), .state_o(st_a)
`ifdef HAZARD_PERF_CNT_EN
       ,.lu_stall_cnt_o(lu_a), .flush_cnt_o(fc_a), .mem_wait_cnt_o(mw_a)
`endif
    );

    hazard_ctrl #(.LOAD_USE_CYCLES(3), .FLUSH_CYCLES(2)) dut_b (
        .clk_i(clk), .rst_i(rst),
        .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
        .id_rs1_used_i(id_rs1_used), .id_rs2_used_i(id_rs2_used),
        .ex_rd_i(ex_rd), .ex_wen_i(ex_wen), .ex_is_load_i(ex_is_load),
        .ex_redirect_i(ex_redirect), .mem_busy_i(mem_busy),
        .keep_pc_o(kp_b), .keep_if_id_o(ki_b), .keep_id_ex_o(ke_b),
        .flush_if_id_o(fl_b), .bubble_id_ex_o(bb_b), .state_o(st_b)
`ifdef HAZARD_PERF_CNT_EN
       ,.lu_stall_cnt_o(lu_b), .flush_cnt_o(fc_b), .mem_wait_cnt_o(mw_b)
`endif
    );

    task automatic vec(input string nm, input logic r,
                       input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2,
                       input logic [4:0] rd, input logic wen, input logic ld,
                       input logic redir, input logic busy,
                       input logic [6:0] ea, input logic [6:0] eb);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
        ex_rd = rd; ex_wen = wen; ex_is_load = ld; ex_redirect = redir; mem_busy = busy;
        e.ea = ea; e.eb = eb; e.name = nm;
        sb_q.push_back(e);
    endtask

    task automatic idle(input string nm, input logic [6:0] ea, input logic [6:0] eb);
        vec(nm, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, ea, eb);
    endtask

    // Load into x5 in EX with ID reading x5 through rs2
    task automatic lu5(input string nm, input logic redir, input logic busy,
                       input logic [6:0] ea, input logic [6:0] eb);
        vec(nm, 1'b0, 5'd1, 1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1, redir, busy, ea, eb);
    endtask

    task automatic busy_only(input string nm, input logic redir,
                             input logic [6:0] ea, input logic [6:0] eb);
        vec(nm, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, redir, 1'b1, ea, eb);
    endtask

    // Monitor: outputs are valid every cycle, compared at the falling edge
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            logic [6:0] got_a, got_b;
            e     = sb_q.pop_front();
            got_a = {st_a, kp_a, ki_a, ke_a, fl_a, bb_a};
            got_b = {st_b, kp_b, ki_b, ke_b, fl_b, bb_b};
            total = total + 1;
            if (got_a === e.ea) passed = passed + 1;
            else $display("FAIL %s[L1F1] got %b expected %b", e.name, got_a, e.ea);
            total = total + 1;
            if (got_b === e.eb) passed = passed + 1;
            else $display("FAIL %s[L3F2] got %b expected %b", e.name, got_b, e.eb);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec("reset", 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_RST, E_RST);
        idle("idle0", E_IDLE, E_IDLE);
        lu5 ("lu_rs2", 1'b0, 1'b0, E_LU, E_LU);
        idle("lu_s1", E_IDLE, E_LUS);
        idle("lu_s2", E_IDLE, E_LUS);
        idle("lu_end", E_IDLE, E_IDLE);
        vec("lu_x0", 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, E_IDLE, E_IDLE);
        vec("lu_unused", 1'b0, 5'd1, 1'b0, 5'd5, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, E_IDLE, E_IDLE);
        vec("lu_rs1", 1'b0, 5'd7, 1'b1, 5'd3, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, E_LU, E_LU);
        idle("lu1_s1", E_IDLE, E_LUS);
        idle("lu1_s2", E_IDLE, E_LUS);
        lu5 ("redir_lu", 1'b1, 1'b0, E_RED, E_RED);
        idle("flush1", E_IDLE, E_FL);
        idle("flush_end", E_IDLE, E_IDLE);
        lu5 ("lu_pre_busy", 1'b0, 1'b0, E_LU, E_LU);
        busy_only("busy0", 1'b0, E_MB0, E_MB1);
        busy_only("busy1", 1'b0, E_MW, E_MW);
        busy_only("busy2", 1'b0, E_MW, E_MW);
        busy_only("busy3", 1'b0, E_MW, E_MW);
        idle("resume1", E_MW_RUN, E_MW_LU);
        idle("resume2", E_IDLE, E_LUS);
        idle("resume_end", E_IDLE, E_IDLE);
        vec("redir0", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, E_RED, E_RED);
        vec("redir_in_fl", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, E_RED, E_FLR);
        vec("rst_mid_fl", 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_RST, E_RST);
        idle("post_rst", E_IDLE, E_IDLE);
        lu5 ("lu_again", 1'b0, 1'b0, E_LU, E_LU);
        busy_only("busy_redir", 1'b1, E_MB0, E_MB1);
        idle("resume_b1", E_MW_RUN, E_MW_LU);
        idle("resume_b2", E_IDLE, E_LUS);
        idle("final", E_IDLE, E_IDLE);
        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
        if (sb_q.size() != 0) begin
            total = total + 1;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
